c2d_scan_ctrl: RTL
==================

C2D_SCAN_CTRL -- requirements
Module: c2d_scan_ctrl

Interface
REQ-001 SHALL have parameter pVEC_X, default 28, input image width in pixels.
REQ-002 SHALL have parameter pVEC_Y, default 28, input image height in pixels.
REQ-003 SHALL have parameter pKER_X, default 3, kernel width.
REQ-004 SHALL have parameter pKER_Y, default 3, kernel height.
REQ-005 SHALL have parameter pSTRIDE, default 1, window step in both axes (>=1).
REQ-006 SHALL have parameter pCH, default 1, input channel count (>=1).
REQ-007 SHALL have ports: iclk in 1, clock; irst in 1, reset (synchronous, active-high).
REQ-008 SHALL have ports: istart in 1, start pulse; iabort in 1, abort request; iready in 1, MAC engine accepts element.
REQ-009 SHALL have ports: ocalc_en out 1, element valid; oaddr out lpAW, feature-memory address; okaddr out lpKW, kernel-memory address.
REQ-010 SHALL have ports: ofirst out 1, first element of window; olast out 1, last element of window; owin_x out lpOXW, window column; owin_y out lpOYW, window row.
REQ-011 SHALL have ports: obusy out 1, scan in progress; odone out 1, single-cycle completion pulse.

Function
REQ-012 SHALL derive lpOUT_X=(pVEC_X-pKER_X)/pSTRIDE+1 and lpOUT_Y=(pVEC_Y-pKER_Y)/pSTRIDE+1 using floor division; trailing pixels not covered by a full window are skipped.
REQ-013 SHALL derive lpAW=clog2(pVEC_X*pVEC_Y*pCH) and lpKW=clog2(pKER_X*pKER_Y*pCH), each with a minimum of 1.
REQ-014 SHALL use the FSM states sIDLE, sRUN, and sEND.
REQ-015 SHALL, in sIDLE, transition to sRUN on istart=1, clear all counters, and drive ocalc_en=1 on the following cycle.
REQ-016 SHALL iterate in nesting order kx (fastest), ky, ch, window x, window y (slowest).
REQ-017 SHALL advance exactly one element per cycle where ocalc_en&&iready=1, and hold all outputs stable while iready=0.
REQ-018 SHALL drive oaddr=ch*pVEC_X*pVEC_Y+(owin_y*pSTRIDE+ky)*pVEC_X+(owin_x*pSTRIDE+kx).
REQ-019 SHALL drive okaddr=ch*pKER_X*pKER_Y+ky*pKER_X+kx.
REQ-020 SHALL assert ofirst when kx=ky=ch=0, and olast when kx=pKER_X-1, ky=pKER_Y-1 and ch=pCH-1, in both cases only while ocalc_en=1.
REQ-021 SHALL, on acceptance of the last element of the last window, go to sEND with ocalc_en=0; sEND SHALL pulse odone for one cycle and then return to sIDLE.
REQ-022 SHALL hold obusy=1 in sRUN and sEND and 0 in sIDLE.
REQ-023 SHALL ignore istart outside sIDLE.
REQ-024 SHALL, on iabort=1 in any state, enter sIDLE next cycle with ocalc_en=0, no odone pulse, and counters cleared; iabort has priority over istart and over acceptance in the same cycle.
REQ-025 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-026 SHALL, on irst=1, force state sIDLE, all counters 0, ocalc_en=ofirst=olast=obusy=odone=0, and oaddr=okaddr=owin_x=owin_y=0.
REQ-027 SHALL give reset priority over iabort, istart and iready; reset mid-scan SHALL discard progress without asserting odone.

Structure
REQ-028 SHALL place the state enum and a clog2-with-minimum-1 width function in shared package c2d_pkg.
REQ-029 SHALL implement each of the five loop counters as an instance of sub-module c2d_wrap_cnt (parameter MAX; ports inc, clr, value, wrap), chained by wrap flags.
REQ-030 SHALL compute addresses incrementally (adds only) with no multipliers in the datapath; products of parameters are constants.

Verification
REQ-031 SHALL cover: 4x4 image, 3x3 kernel, stride 1, pCH=1, iready=1 -> 36 ocalc_en cycles; first oaddr=0; olast at oaddr=10 for window (0,0); final oaddr=15; odone one cycle after that element.
REQ-032 SHALL cover: 5x5 image, 3x3 kernel, stride 2 -> 4 windows; window (1,0) first oaddr=2; window (1,1) first oaddr=12.
REQ-033 SHALL cover: 4x4 image, 3x3 kernel, pCH=2 -> 72 elements; the element after okaddr=8 has okaddr=9 and oaddr=16, with ofirst=0.
REQ-034 SHALL cover: iready toggled pseudo-randomly -> the address sequence is identical to the iready=1 run, and outputs are stable during stalls.
REQ-035 SHALL cover: iabort at element 10, followed by istart -> no odone for the aborted scan; the new scan restarts at oaddr=0.
REQ-036 SHALL cover: istart pulsed during sRUN, and irst mid-scan -> istart is ignored; irst gives all-zero outputs the next cycle and no odone.

Source files
------------

// File: rtl/c2d_pkg.sv
// Shared definitions for the convolution scan controller: FSM state encoding
// and the width helper used to size every counter and address port.
package c2d_pkg;

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sRUN  = 2'd1,
        sEND  = 2'd2
    } c2d_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/c2d_wrap_cnt.sv
// Modulo-MAX counter with a carry-style wrap flag so that counters can be
// chained: the wrap of one counter is the increment of the next.
module c2d_wrap_cnt
    import c2d_pkg::*;
#(
    parameter  int MAX = 4,
    localparam int W   = clog2_min1(MAX)
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    assign wrap = inc && (value == W'(MAX - 1));

    always_ff @(posedge iclk) begin
        if (irst || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/c2d_scan_ctrl.sv
// Convolution scan controller: walks every kernel element of every output
// window and emits feature/kernel memory addresses to a MAC engine.
module c2d_scan_ctrl
    import c2d_pkg::*;
#(
    parameter  int pVEC_X  = 28,
    parameter  int pVEC_Y  = 28,
    parameter  int pKER_X  = 3,
    parameter  int pKER_Y  = 3,
    parameter  int pSTRIDE = 1,
    parameter  int pCH     = 1,
    localparam int lpOUT_X = (pVEC_X - pKER_X) / pSTRIDE + 1,
    localparam int lpOUT_Y = (pVEC_Y - pKER_Y) / pSTRIDE + 1,
    localparam int lpAW    = clog2_min1(pVEC_X * pVEC_Y * pCH),
    localparam int lpKW    = clog2_min1(pKER_X * pKER_Y * pCH),
    localparam int lpOXW   = clog2_min1(lpOUT_X),
    localparam int lpOYW   = clog2_min1(lpOUT_Y)
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             istart,
    input  logic             iabort,
    input  logic             iready,
    output logic             ocalc_en,
    output logic [lpAW-1:0]  oaddr,
    output logic [lpKW-1:0]  okaddr,
    output logic             ofirst,
    output logic             olast,
    output logic [lpOXW-1:0] owin_x,
    output logic [lpOYW-1:0] owin_y,
    output logic             obusy,
    output logic             odone,
    output logic [1:0]       odbg_state
);

    // Address steps taken when the given counter wraps into the next one.
    localparam int lpD_KY = pVEC_X - (pKER_X - 1);
    localparam int lpD_CH = pVEC_X * pVEC_Y - (pKER_Y - 1) * pVEC_X - (pKER_X - 1);
    localparam int lpD_WY = pSTRIDE * pVEC_X;

    localparam int lpKXW = clog2_min1(pKER_X);
    localparam int lpKYW = clog2_min1(pKER_Y);
    localparam int lpCHW = clog2_min1(pCH);

    c2d_state_t state, state_n;

    logic [lpKXW-1:0] kx_v;
    logic [lpKYW-1:0] ky_v;
    logic [lpCHW-1:0] ch_v;
    logic kx_wrap, ky_wrap, ch_wrap, wx_wrap, wy_wrap;
    logic adv, cnt_clr;

    logic [lpAW-1:0] addr_n, win_q, win_n, row_q, row_n;
    logic [lpKW-1:0] kaddr_n;

    // Handshake: an element is transferred on every rising edge where
    // ocalc_en && iready; while iready is low every output holds its value.
    assign adv     = ocalc_en && iready && !iabort;
    assign cnt_clr = iabort || (state == sIDLE);

    assign odbg_state = state;
    assign ofirst = ocalc_en && (kx_v == '0) && (ky_v == '0) && (ch_v == '0);
    assign olast  = ocalc_en && (kx_v == lpKXW'(pKER_X - 1))
                             && (ky_v == lpKYW'(pKER_Y - 1))
                             && (ch_v == lpCHW'(pCH - 1));

    c2d_wrap_cnt #(.MAX(pKER_X)) u_kx (
        .iclk(iclk), .irst(irst), .inc(adv), .clr(cnt_clr), .value(kx_v), .wrap(kx_wrap)
    );
    c2d_wrap_cnt #(.MAX(pKER_Y)) u_ky (
        .iclk(iclk), .irst(irst), .inc(kx_wrap), .clr(cnt_clr), .value(ky_v), .wrap(ky_wrap)
    );
    c2d_wrap_cnt #(.MAX(pCH)) u_ch (
        .iclk(iclk), .irst(irst), .inc(ky_wrap), .clr(cnt_clr), .value(ch_v), .wrap(ch_wrap)
    );
    c2d_wrap_cnt #(.MAX(lpOUT_X)) u_wx (
        .iclk(iclk), .irst(irst), .inc(ch_wrap), .clr(cnt_clr), .value(owin_x), .wrap(wx_wrap)
    );
    c2d_wrap_cnt #(.MAX(lpOUT_Y)) u_wy (
        .iclk(iclk), .irst(irst), .inc(wx_wrap), .clr(cnt_clr), .value(owin_y), .wrap(wy_wrap)
    );

    always_comb begin
        state_n = state;
        case (state)
            sIDLE:   if (istart) state_n = sRUN;
            sRUN:    if (adv && wy_wrap) state_n = sEND;
            sEND:    state_n = sIDLE;
            default: state_n = sIDLE;
        endcase
        if (iabort) state_n = sIDLE;
    end

    // Window origin (win_q) and window-row origin (row_q) let every address
    // step be a constant add instead of a multiply.
    always_comb begin
        addr_n  = oaddr;
        kaddr_n = okaddr;
        win_n   = win_q;
        row_n   = row_q;
        if (cnt_clr) begin
            addr_n  = '0;
            kaddr_n = '0;
            win_n   = '0;
            row_n   = '0;
        end else if (adv) begin
            kaddr_n = ch_wrap ? '0 : okaddr + lpKW'(1);
            if (!kx_wrap) begin
                addr_n = oaddr + lpAW'(1);
            end else if (!ky_wrap) begin
                addr_n = oaddr + lpAW'(lpD_KY);
            end else if (!ch_wrap) begin
                addr_n = oaddr + lpAW'(lpD_CH);
            end else if (!wx_wrap) begin
                win_n  = win_q + lpAW'(pSTRIDE);
                addr_n = win_n;
            end else if (!wy_wrap) begin
                row_n  = row_q + lpAW'(lpD_WY);
                win_n  = row_n;
                addr_n = row_n;
            end else begin
                addr_n = '0;
                win_n  = '0;
                row_n  = '0;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state    <= sIDLE;
            ocalc_en <= 1'b0;
            obusy    <= 1'b0;
            odone    <= 1'b0;
            oaddr    <= '0;
            okaddr   <= '0;
            win_q    <= '0;
            row_q    <= '0;
        end else begin
            state    <= state_n;
            ocalc_en <= (state_n == sRUN);
            obusy    <= (state_n != sIDLE);
            odone    <= (state_n == sEND);
            oaddr    <= addr_n;
            okaddr   <= kaddr_n;
            win_q    <= win_n;
            row_q    <= row_n;
        end
    end

endmodule
